// File: rtl/cellrv32_board_reset_ctrl_if.sv
// rtl/cellrv32_board_reset_ctrl_if.sv - board-side reset inputs and processor-side reset/RX outputs
interface cellrv32_board_reset_ctrl_if;
  logic       key_ni;
  logic       pll_locked_i;
  logic       sw_rst_req_i;
  logic       uart_rxd_i;
  logic       uart_rxd_o;
  logic       rstn_o;
  logic [1:0] rst_cause_o;

  // board/bench side: drives raw inputs, observes conditioned outputs
  modport master (
    output key_ni, pll_locked_i, sw_rst_req_i, uart_rxd_i,
    input  uart_rxd_o, rstn_o, rst_cause_o
  );

  // reset controller side
  modport slave (
    input  key_ni, pll_locked_i, sw_rst_req_i, uart_rxd_i,
    output uart_rxd_o, rstn_o, rst_cause_o
  );
endinterface

// File: rtl/cellrv32_board_reset_ctrl.sv
// rtl/cellrv32_board_reset_ctrl.sv - board reset sequencer, key debouncer and UART RX synchronizer (optional debounce: CELLRV32_RSTGEN_DEBOUNCE_EN)
module cellrv32_board_reset_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 1024
) (
  input logic                         clk_i,
  input logic                         rstn_i,
  cellrv32_board_reset_ctrl_if.slave  bus
);

  localparam int HW = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic          key_meta, key_sync;
  logic          pll_meta, pll_sync;
  logic          rxd_meta, rxd_sync;
  logic          key_stable;
  logic          src;
  state_t        state, state_next;
  logic [HW-1:0] hold_cnt;
  logic          rstn_q;
  logic [1:0]    cause_q;

  // two-flop synchronizers for every asynchronous board input
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      pll_meta <= 1'b0;
      pll_sync <= 1'b0;
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      key_meta <= bus.key_ni;
      key_sync <= key_meta;
      pll_meta <= bus.pll_locked_i;
      pll_sync <= pll_meta;
      rxd_meta <= bus.uart_rxd_i;
      rxd_sync <= rxd_meta;
    end
  end

`ifdef CELLRV32_RSTGEN_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  logic [DW-1:0] deb_cnt;

  // accept a new key level only after it has persisted DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      deb_cnt    <= '0;
      key_stable <= 1'b1;
    end else if (key_sync == key_stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      key_stable <= key_sync;
      deb_cnt    <= '0;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES > 1);
  assign key_stable      = key_sync;
`endif

  assign src = !key_stable || !pll_sync;

  // next-state: wait for sources to clear, stretch, then run until a source or sw request
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: if (!src) state_next = ST_HOLD;
      ST_HOLD: begin
        if (src)                                    state_next = ST_RESET;
        else if (hold_cnt == HW'(HOLD_CYCLES - 1)) state_next = ST_RUN;
      end
      ST_RUN:   if (src || bus.sw_rst_req_i) state_next = ST_RESET;
      default:  state_next = ST_RESET;
    endcase
  end

  // state, hold counter, registered reset output and latched reset cause
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_RESET;
      hold_cnt <= '0;
      rstn_q   <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      state    <= state_next;
      hold_cnt <= (state == ST_HOLD && state_next == ST_HOLD) ? hold_cnt + HW'(1) : '0;
      rstn_q   <= (state_next == ST_RUN);
      if (state != ST_RESET && state_next == ST_RESET) begin
        if (!pll_sync)        cause_q <= 2'b10;
        else if (!key_stable) cause_q <= 2'b01;
        else                  cause_q <= 2'b11;
      end
    end
  end

  assign bus.rstn_o      = rstn_q;
  assign bus.rst_cause_o = cause_q;
  assign bus.uart_rxd_o  = rxd_sync;

endmodule

// File: tb/tb_cellrv32_board_reset_ctrl.sv
// tb/tb_cellrv32_board_reset_ctrl.sv - scoreboard bench for cellrv32_board_reset_ctrl
module tb_cellrv32_board_reset_ctrl;

`ifdef CELLRV32_RSTGEN_DEBOUNCE_EN
  localparam int KD = 16;
  localparam int PW = 10;
`else
  localparam int KD = 0;
  localparam int PW = 3;
`endif

  typedef struct {
    int         cyc;
    logic       val;
    logic [1:0] cause;
  } rst_ev_t;

  typedef struct {
    int   cyc;
    logic val;
  } rx_ev_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  rst_ev_t rst_q[$];
  rx_ev_t  rx_q[$];
  rst_ev_t re;
  rx_ev_t  xe;
  logic    prev_rst, prev_rx;

  cellrv32_board_reset_ctrl_if bus();

  cellrv32_board_reset_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .HOLD_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_rst(input int c, input logic v, input logic [1:0] cs);
    rst_ev_t e;
    e.cyc = c; e.val = v; e.cause = cs;
    rst_q.push_back(e);
  endtask

  task automatic push_rx(input int c, input logic v);
    rx_ev_t e;
    e.cyc = c; e.val = v;
    rx_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every change on rstn_o / uart_rxd_o must match the next expected event
  always @(negedge clk) begin
    while (rst_q.size() > 0 && rst_q[0].cyc < cyc) begin
      re = rst_q.pop_front();
      tests++; fails++;
      $display("FAIL rstn_missing: no edge seen, expected rstn_o=%0b at edge %0d", re.val, re.cyc);
    end
    while (rx_q.size() > 0 && rx_q[0].cyc < cyc) begin
      xe = rx_q.pop_front();
      tests++; fails++;
      $display("FAIL rxd_missing: no edge seen, expected uart_rxd_o=%0b at edge %0d", xe.val, xe.cyc);
    end
    if (!rstn) begin
      prev_rst = bus.rstn_o;
      prev_rx  = bus.uart_rxd_o;
    end else begin
      if (bus.rstn_o !== prev_rst) begin
        tests++;
        if (rst_q.size() == 0) begin
          fails++;
          $display("FAIL rstn_unexpected: rstn_o=%0b at edge %0d, expected no change", bus.rstn_o, cyc);
        end else begin
          re = rst_q.pop_front();
          if (re.cyc != cyc || re.val !== bus.rstn_o || re.cause !== bus.rst_cause_o) begin
            fails++;
            $display("FAIL rstn_event: got rstn_o=%0b cause=%0b at edge %0d, expected rstn_o=%0b cause=%0b at edge %0d",
                     bus.rstn_o, bus.rst_cause_o, cyc, re.val, re.cause, re.cyc);
          end
        end
        prev_rst = bus.rstn_o;
      end
      if (bus.uart_rxd_o !== prev_rx) begin
        tests++;
        if (rx_q.size() == 0) begin
          fails++;
          $display("FAIL rxd_unexpected: uart_rxd_o=%0b at edge %0d, expected no change", bus.uart_rxd_o, cyc);
        end else begin
          xe = rx_q.pop_front();
          if (xe.cyc != cyc || xe.val !== bus.uart_rxd_o) begin
            fails++;
            $display("FAIL rxd_event: got uart_rxd_o=%0b at edge %0d, expected %0b at edge %0d",
                     bus.uart_rxd_o, cyc, xe.val, xe.cyc);
          end
        end
        prev_rx = bus.uart_rxd_o;
      end
    end
  end

  initial begin
    int c, r, h;
    rstn = 1'b0;
    bus.key_ni = 1'b1;
    bus.pll_locked_i = 1'b1;
    bus.sw_rst_req_i = 1'b0;
    bus.uart_rxd_i = 1'b0;
    tick(3);
    check("reset_rstn", int'(bus.rstn_o), 0);
    check("reset_rxd", int'(bus.uart_rxd_o), 1);
    check("reset_cause", int'(bus.rst_cause_o), 0);
    bus.uart_rxd_i = 1'b1;
    tick(1);

    // power-on release
    c = cyc; rstn = 1'b1;
    push_rst(c + 11, 1'b1, 2'b00);
    tick(15);
    check("poweron_cause", int'(bus.rst_cause_o), 0);

    // uart toggles
    c = cyc; bus.uart_rxd_i = 1'b0; push_rx(c + 2, 1'b0);
    tick(5);
    c = cyc; bus.uart_rxd_i = 1'b1; push_rx(c + 2, 1'b1);
    tick(5);

    // short key press: filtered when debounced, otherwise a reset
    c = cyc; bus.key_ni = 1'b0;
    if (KD == 0) begin
      push_rst(c + 3, 1'b0, 2'b01);
      push_rst(c + PW + 11, 1'b1, 2'b01);
    end
    tick(PW); bus.key_ni = 1'b1;
    tick(40);

    // one-cycle PLL loss
    c = cyc; bus.pll_locked_i = 1'b0;
    push_rst(c + 3, 1'b0, 2'b10);
    push_rst(c + 12, 1'b1, 2'b10);
    tick(1); bus.pll_locked_i = 1'b1;
    tick(20);

    // long key press then release
    c = cyc; bus.key_ni = 1'b0;
    push_rst(c + 3 + KD, 1'b0, 2'b01);
    tick(30);
    r = cyc; bus.key_ni = 1'b1;
    push_rst(r + 11 + KD, 1'b1, 2'b01);
    tick(40);

    // key and PLL loss reach the FSM on the same edge: PLL wins
    c = cyc; bus.key_ni = 1'b0;
    tick(KD); bus.pll_locked_i = 1'b0;
    push_rst(c + 3 + KD, 1'b0, 2'b10);
    tick(40 - KD);
    r = cyc; bus.key_ni = 1'b1; bus.pll_locked_i = 1'b1;
    push_rst(r + 11 + KD, 1'b1, 2'b10);
    tick(40);

    // software reset, then a second request during hold is ignored
    c = cyc; bus.sw_rst_req_i = 1'b1;
    push_rst(c + 1, 1'b0, 2'b11);
    push_rst(c + 10, 1'b1, 2'b11);
    tick(1); bus.sw_rst_req_i = 1'b0;
    tick(2); bus.sw_rst_req_i = 1'b1;
    tick(1); bus.sw_rst_req_i = 1'b0;
    tick(20);

    // PLL drop lands on hold count 7: back to reset, no high pulse
    c = cyc; bus.sw_rst_req_i = 1'b1;
    push_rst(c + 1, 1'b0, 2'b11);
    h = c + 2;
    tick(1); bus.sw_rst_req_i = 1'b0;
    tick(6); bus.pll_locked_i = 1'b0;
    tick(1); bus.pll_locked_i = 1'b1;
    push_rst(h + 17, 1'b1, 2'b10);
    tick(25);

    // board reset asserted mid-hold
    c = cyc; bus.sw_rst_req_i = 1'b1;
    push_rst(c + 1, 1'b0, 2'b11);
    tick(1); bus.sw_rst_req_i = 1'b0; bus.uart_rxd_i = 1'b0;
    push_rx(c + 3, 1'b0);
    tick(4);
    check("midhold_cause_before", int'(bus.rst_cause_o), 3);
    #2 rstn = 1'b0;
    #1;
    check("midhold_rstn", int'(bus.rstn_o), 0);
    check("midhold_rxd", int'(bus.uart_rxd_o), 1);
    check("midhold_cause", int'(bus.rst_cause_o), 0);
    bus.uart_rxd_i = 1'b1;
    tick(2);
    c = cyc; rstn = 1'b1;
    push_rst(c + 11, 1'b1, 2'b00);
    tick(20);
    check("final_rstn", int'(bus.rstn_o), 1);

    tick(2);
    while (rst_q.size() > 0) begin
      re = rst_q.pop_front();
      tests++; fails++;
      $display("FAIL rstn_pending: expected rstn_o=%0b at edge %0d never seen", re.val, re.cyc);
    end
    while (rx_q.size() > 0) begin
      xe = rx_q.pop_front();
      tests++; fails++;
      $display("FAIL rxd_pending: expected uart_rxd_o=%0b at edge %0d never seen", xe.val, xe.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
